pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, M, WB).
- Replaces the fixed load-use stall logic with a configurable multi-cycle stall FSM.
- Adds IF/ID flush on a redirect taken in ID (branch/jump), EX-operand forwarding select, and saturating performance counters.
- Drives the PC write enable, IF/ID write enable, IF/ID flush and the ID/EX bubble.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/fwd_select.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and state encoding for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forwarding source select with M-over-WB priority
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              m_reg_write,
    input  logic [REG_AW-1:0] m_dst,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    output logic [1:0]        fwd
);

    logic src_ok;

    // Register 0 is hardwired, so a write to it is never a real producer
    assign src_ok = !((ZERO_REG != 0) && (src == '0));

    // Youngest producer (M) wins over the older one (WB)
    always_comb begin
        fwd = FWD_REG;
        if (src_ok && m_reg_write && (m_dst == src)) begin
            fwd = FWD_MEM;
        end else if (src_ok && wb_reg_write && (wb_dst == src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall FSM, redirect flush, EX forwarding and perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LU_BUBBLES = 1,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              m_reg_write,
    input  logic [REG_AW-1:0] m_dst,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              redirect_req,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int BCNT_W = $clog2(LU_BUBBLES + 1);

    hz_state_t         state, state_nxt;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
    logic              ex_dst_ok;
    logic              hz;
    logic              stall;
    logic [1:0]        fwd_a_raw, fwd_b_raw;

    assign ex_dst_ok = !((ZERO_REG != 0) && (ex_dst == '0));
    assign hz = ex_mem_read && ex_dst_ok &&
                ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));

    // State and remaining-bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // First bubble is issued from RUN; STALL supplies the remaining LU_BUBBLES-1
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        stall     = 1'b0;
        case (state)
            ST_RUN: begin
                if (hz) begin
                    stall = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_nxt = ST_STALL;
                        bcnt_nxt  = BCNT_W'(LU_BUBBLES - 1);
                    end
                end
            end
            ST_STALL: begin
                stall    = 1'b1;
                bcnt_nxt = bcnt - BCNT_W'(1);
                if (bcnt == BCNT_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                bcnt_nxt  = '0;
            end
        endcase
    end

    fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .src          (ex_rs),
        .m_reg_write  (m_reg_write),
        .m_dst        (m_dst),
        .wb_reg_write (wb_reg_write),
        .wb_dst       (wb_dst),
        .fwd          (fwd_a_raw)
    );

    fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .src          (ex_rt),
        .m_reg_write  (m_reg_write),
        .m_dst        (m_dst),
        .wb_reg_write (wb_reg_write),
        .wb_dst       (wb_dst),
        .fwd          (fwd_b_raw)
    );

    // Reset forces a frozen, bubbling pipeline; a stall masks any redirect
    always_comb begin
        pc_write     = !rst && !stall;
        if_id_write  = !rst && !stall;
        id_ex_bubble = rst || stall;
        if_id_flush  = !rst && redirect_req && (state == ST_RUN) && !stall;
        fwd_a        = rst ? FWD_REG : fwd_a_raw;
        fwd_b        = rst ? FWD_REG : fwd_b_raw;
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed checks of the hazard controller at 1, 3 and 4 bubbles
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_dst, ex_rs, ex_rt, m_dst, wb_dst;
    logic       id_use_rs, id_use_rt, ex_mem_read, m_reg_write, wb_reg_write, redirect_req;

    logic        a_pc, a_ifw, a_fl, a_bub;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_sc, a_fe;
    logic        b_pc, b_ifw, b_fl, b_bub;
    logic [1:0]  b_fa, b_fb;
    logic [15:0] b_sc, b_fe;
    logic        c_pc, c_ifw, c_fl, c_bub;
    logic [1:0]  c_fa, c_fb;
    logic [3:0]  c_sc, c_fe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(1), .ZERO_REG(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .m_reg_write(m_reg_write), .m_dst(m_dst), .wb_reg_write(wb_reg_write),
        .wb_dst(wb_dst), .redirect_req(redirect_req), .pc_write(a_pc), .if_id_write(a_ifw),
        .if_id_flush(a_fl), .id_ex_bubble(a_bub), .fwd_a(a_fa), .fwd_b(a_fb),
        .stall_cycles(a_sc), .flush_events(a_fe)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(3), .ZERO_REG(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .m_reg_write(m_reg_write), .m_dst(m_dst), .wb_reg_write(wb_reg_write),
        .wb_dst(wb_dst), .redirect_req(redirect_req), .pc_write(b_pc), .if_id_write(b_ifw),
        .if_id_flush(b_fl), .id_ex_bubble(b_bub), .fwd_a(b_fa), .fwd_b(b_fb),
        .stall_cycles(b_sc), .flush_events(b_fe)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(4), .ZERO_REG(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .m_reg_write(m_reg_write), .m_dst(m_dst), .wb_reg_write(wb_reg_write),
        .wb_dst(wb_dst), .redirect_req(redirect_req), .pc_write(c_pc), .if_id_write(c_ifw),
        .if_id_flush(c_fl), .id_ex_bubble(c_bub), .fwd_a(c_fa), .fwd_b(c_fb),
        .stall_cycles(c_sc), .flush_events(c_fe)
    );

    typedef struct {
        logic       mr;
        logic [4:0] exd, irs, irt;
        logic       urs, urt, rd, mw;
        logic [4:0] md;
        logic       ww;
        logic [4:0] wd, ers, ert;
        logic       pc, ifw, bub, fl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_mem_read = 0; ex_dst = 0; ex_rs = 0; ex_rt = 0;
        m_reg_write = 0; m_dst = 0; wb_reg_write = 0; wb_dst = 0;
        redirect_req = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    initial begin
        //       mr exd   irs   irt   urs urt rd mw md    ww wd    ers   ert    pc ifw bub fl fa     fb
        vt[0]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00};
        vt[1]  = '{1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00};
        vt[2]  = '{1, 5'd9, 5'd1, 5'd9, 0, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00};
        vt[3]  = '{1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00};
        vt[4]  = '{1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00};
        vt[5]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 2'b00, 2'b00};
        vt[6]  = '{1, 5'd8, 5'd8, 5'd0, 1, 0, 1, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00};
        vt[7]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 5'd5, 5'd7, 1, 1, 0, 0, 2'b10, 2'b00};
        vt[8]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd5, 1, 5'd5, 5'd5, 5'd7, 1, 1, 0, 0, 2'b01, 2'b00};
        vt[9]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00};
        vt[10] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd3, 1, 5'd3, 5'd3, 5'd3, 1, 1, 0, 0, 2'b10, 2'b10};
        vt[11] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd3, 1, 5'd4, 5'd3, 5'd4, 1, 1, 0, 0, 2'b10, 2'b01};

        // Reset state, with active-looking inputs that must be masked
        clear_inputs();
        set_load_use();
        redirect_req = 1; m_reg_write = 1; m_dst = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
        @(negedge clk);
        chk("rst_pc", a_pc, 0);
        chk("rst_ifw", a_ifw, 0);
        chk("rst_bub", a_bub, 1);
        chk("rst_flush", a_fl, 0);
        chk("rst_fwd_a", a_fa, 2'b00);
        chk("rst_fwd_b", a_fb, 2'b00);
        chk("rst_stall_cnt", a_sc, 0);
        chk("rst_flush_cnt", a_fe, 0);
        next_cycle();
        clear_inputs();
        rst = 0;

        // Combinational table on the single-bubble instance (it never leaves RUN)
        for (int i = 0; i < 12; i++) begin
            ex_mem_read = vt[i].mr; ex_dst = vt[i].exd; id_rs = vt[i].irs; id_rt = vt[i].irt;
            id_use_rs = vt[i].urs; id_use_rt = vt[i].urt; redirect_req = vt[i].rd;
            m_reg_write = vt[i].mw; m_dst = vt[i].md; wb_reg_write = vt[i].ww; wb_dst = vt[i].wd;
            ex_rs = vt[i].ers; ex_rt = vt[i].ert;
            @(negedge clk);
            chk($sformatf("vec%0d_pc", i), a_pc, vt[i].pc);
            chk($sformatf("vec%0d_ifw", i), a_ifw, vt[i].ifw);
            chk($sformatf("vec%0d_bub", i), a_bub, vt[i].bub);
            chk($sformatf("vec%0d_flush", i), a_fl, vt[i].fl);
            chk($sformatf("vec%0d_fwd_a", i), a_fa, vt[i].fa);
            chk($sformatf("vec%0d_fwd_b", i), a_fb, vt[i].fb);
            next_cycle();
        end

        // Single load-use event seen by all three bubble depths
        do_reset();
        set_load_use();                       // cycle 1
        @(negedge clk);
        chk("c1_a_pc", a_pc, 0);
        chk("c1_a_bub", a_bub, 1);
        chk("c1_b_pc", b_pc, 0);
        chk("c1_c_pc", c_pc, 0);
        next_cycle();
        clear_inputs();                       // cycle 2: EX now holds a bubble
        @(negedge clk);
        chk("c2_a_pc", a_pc, 1);
        chk("c2_a_bub", a_bub, 0);
        chk("c2_a_stall_cnt", a_sc, 1);
        chk("c2_b_pc", b_pc, 0);
        chk("c2_b_ifw", b_ifw, 0);
        chk("c2_b_bub", b_bub, 1);
        chk("c2_c_pc", c_pc, 0);
        next_cycle();
        redirect_req = 1;                     // cycle 3: redirect during a stall
        @(negedge clk);
        chk("c3_a_flush", a_fl, 1);
        chk("c3_b_pc", b_pc, 0);
        chk("c3_b_flush", b_fl, 0);
        chk("c3_c_flush", c_fl, 0);
        next_cycle();
        redirect_req = 0;                     // cycle 4
        @(negedge clk);
        chk("c4_b_pc", b_pc, 1);
        chk("c4_b_bub", b_bub, 0);
        chk("c4_b_stall_cnt", b_sc, 3);
        chk("c4_b_flush_cnt", b_fe, 0);
        chk("c4_a_flush_cnt", a_fe, 1);
        chk("c4_a_flush_once", a_fl, 0);
        chk("c4_c_pc", c_pc, 0);
        next_cycle();                         // cycle 5
        @(negedge clk);
        chk("c5_c_pc", c_pc, 1);
        chk("c5_c_stall_cnt", c_sc, 4);
        next_cycle();
        set_load_use();                       // cycle 6: stall beats redirect
        redirect_req = 1;
        @(negedge clk);
        chk("c6_a_flush", a_fl, 0);
        chk("c6_a_pc", a_pc, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("c7_a_flush_cnt", a_fe, 1);
        chk("c7_a_stall_cnt", a_sc, 2);

        // Asynchronous reset in the second stall cycle of the 4-bubble instance
        do_reset();
        set_load_use();
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("mid_c_pc_before", c_pc, 0);
        chk("mid_c_cnt_before", c_sc, 1);
        redirect_req = 1; m_reg_write = 1; m_dst = 5'd6; ex_rs = 5'd6;
        rst = 1;
        #1;
        chk("mid_c_pc", c_pc, 0);
        chk("mid_c_ifw", c_ifw, 0);
        chk("mid_c_bub", c_bub, 1);
        chk("mid_c_flush", c_fl, 0);
        chk("mid_c_fwd_a", c_fa, 2'b00);
        chk("mid_c_stall_cnt", c_sc, 0);
        next_cycle();
        clear_inputs();
        rst = 0;
        @(negedge clk);
        chk("post_c_pc", c_pc, 1);
        chk("post_c_ifw", c_ifw, 1);
        chk("post_c_bub", c_bub, 0);
        next_cycle();
        @(negedge clk);
        chk("post_c_stall_cnt", c_sc, 0);
        chk("post_c_flush_cnt", c_fe, 0);

        // Counter saturation: 20 stall cycles into a 4-bit counter
        do_reset();
        set_load_use();
        for (int k = 0; k < 20; k++) begin
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk("sat_c_stall_cnt", c_sc, 15);
        chk("sat_a_stall_cnt", a_sc, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
